// File: rtl/grid_readout.sv
// Drain engine for the gridding accumulator BRAM.
// Scans every row in order, streams each row out over valid/ready and
// optionally writes the row back to zero once its read data has returned.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; clear_en is captured with start
// SCAN  | issuing row reads while output credit is available
// DRAIN | all reads issued; waiting for pipeline, FIFO and clears
// DONE  | single-cycle completion pulse
module grid_readout #(
  parameter int COMPLEX               = 2,
  parameter int PRECISION             = 32,
  parameter int BRAM_PARALLELISM_BITS = 4,
  parameter int BRAM_DEPTH_BITS       = 10,
  parameter int READ_LATENCY          = 2,
  parameter int FIFO_DEPTH            = 4,
  localparam int ROWS       = 2**BRAM_DEPTH_BITS,
  localparam int BRAM_WIDTH = (2**BRAM_PARALLELISM_BITS)*PRECISION*COMPLEX,
  localparam int ADDR_W     = BRAM_DEPTH_BITS+BRAM_PARALLELISM_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear_en,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          bram_addr_r,
  input  logic [BRAM_WIDTH-1:0]      bram_dout,
  output logic [ADDR_W-1:0]          bram_addr_w,
  output logic [BRAM_WIDTH-1:0]      bram_din,
  output logic                       bram_we,
  output logic [BRAM_WIDTH-1:0]      out_data,
  output logic [BRAM_DEPTH_BITS-1:0] out_row,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int PB = BRAM_PARALLELISM_BITS;
  localparam int DB = BRAM_DEPTH_BITS;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [DB:0]             issue_cnt;
  logic [DB-1:0]           addr_row;
  logic                    clear_lat;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DB-1:0]           pipe_row [READ_LATENCY];
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [BRAM_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [DB-1:0]           fifo_row [FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [CW:0]             credit_used;
  logic                    credit_ok;
  logic                    issue;
  logic                    push;
  logic                    pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid   = (fifo_count != '0);
  assign out_data    = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_row     = out_valid ? fifo_row[rd_ptr] : '0;
  assign out_last    = out_valid && (fifo_row[rd_ptr] == DB'(ROWS-1));
  assign busy        = (state == SCAN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign bram_addr_r = {addr_row, {PB{1'b0}}};
  assign bram_din    = '0;

  // Read issue gating: credit uses registered counts only, so a pop this
  // cycle frees its slot next cycle and the FIFO can never overflow.
  always_comb begin
    credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);
    issue       = (state == SCAN) && (issue_cnt < (DB+1)'(ROWS)) && credit_ok;
    push        = pipe_vld[READ_LATENCY-1];
    pop         = out_valid && out_ready;
  end

  // Next-state logic; DRAIN looks ahead one cycle so done follows the
  // final handshake directly (inflight==0 also implies no push this cycle).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (issue && (issue_cnt == (DB+1)'(ROWS-1))) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && (fifo_count == CW'(pop))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Issue counter and read address; the address holds at the last row
  // rather than wrapping so it keeps its final value after the scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      addr_row  <= '0;
      clear_lat <= 1'b0;
    end else if ((state == IDLE) && start) begin
      issue_cnt <= '0;
      addr_row  <= '0;
      clear_lat <= clear_en;
    end else if (issue) begin
      issue_cnt <= issue_cnt + (DB+1)'(1);
      if (issue_cnt != (DB+1)'(ROWS-1)) addr_row <= addr_row + DB'(1);
    end
  end

  // Read pipeline tracking {valid,row} in step with the BRAM latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_row[i] <= '0;
    end else begin
      pipe_vld[0] <= issue;
      pipe_row[0] <= addr_row;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_row[i] <= pipe_row[i-1];
      end
    end
  end

  // Outstanding read count and FIFO occupancy/pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight   <= '0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      inflight   <= inflight + CW'(issue) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // FIFO storage; outputs are gated by out_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bram_dout;
      fifo_row[wr_ptr]  <= pipe_row[READ_LATENCY-1];
    end
  end

  // Clear write for each returning row, one cycle after its data arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bram_we     <= 1'b0;
      bram_addr_w <= '0;
    end else begin
      bram_we <= clear_lat && push;
      if (clear_lat && push) bram_addr_w <= {pipe_row[READ_LATENCY-1], {PB{1'b0}}};
    end
  end

endmodule

// File: tb/tb_grid_readout.sv
// Bench for grid_readout: BRAM model, randomized ready/data, scoreboard of
// expected row beats checked by an independent monitor.
module tb_grid_readout;
  localparam int PB   = 4;
  localparam int DB   = 3;
  localparam int RL   = 2;
  localparam int FD   = 4;
  localparam int ROWS = 1 << DB;
  localparam int BW   = (1 << PB) * 64;
  localparam int AW   = DB + PB;

  logic clk = 0, rst = 1, start = 0, clear_en = 0, out_ready = 0;
  logic busy, done, bram_we, out_last, out_valid;
  logic [AW-1:0] bram_addr_r, bram_addr_w;
  logic [BW-1:0] bram_dout, bram_din, out_data;
  logic [DB-1:0] out_row;

  int checks = 0, errors = 0, cyc = 0;
  logic [BW-1:0] mem [ROWS];
  logic [BW-1:0] rd_pipe [RL];
  logic [BW-1:0] snap [ROWS];
  int load_mode = 0, rdy_mode = 0, start_cyc = 0;
  bit scan_clr = 0;

  typedef struct {logic [BW-1:0] data; int row; bit last;} beat_t;
  beat_t exp_q[$];
  beat_t mon_e;

  int beat_cnt, first_valid_cyc, we_total, acc_total, done_cnt, done_cyc, mon_r;
  int beat_cyc [ROWS];
  int we_cnt [ROWS];
  int we_cyc [ROWS];
  bit prev_stall = 0;
  logic [BW-1:0] prev_data;
  logic [DB-1:0] prev_row;
  logic prev_last;

  grid_readout #(
    .COMPLEX(2), .PRECISION(32), .BRAM_PARALLELISM_BITS(PB),
    .BRAM_DEPTH_BITS(DB), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear_en(clear_en),
    .busy(busy), .done(done), .bram_addr_r(bram_addr_r), .bram_dout(bram_dout),
    .bram_addr_w(bram_addr_w), .bram_din(bram_din), .bram_we(bram_we),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered read with RL cycles of latency, plus bulk preload.
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bram_addr_r[AW-1:PB]];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (load_mode != 0) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < (1 << PB); k++)
          mem[r][k*64 +: 64] <= (load_mode == 1) ? {32'(r), 32'(k)} : {$urandom(), $urandom()};
    end else if (bram_we) begin
      mem[bram_addr_w[AW-1:PB]] <= bram_din;
    end
  end
  assign bram_dout = rd_pipe[RL-1];

  // Consumer ready pattern.
  initial begin
    bit [3:0] pat;
    pat = 4'b1001;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = pat[(cyc - start_cyc) % 4];
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ((cyc - start_cyc) > 20);
      endcase
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: stability, scoreboard pops, clear-write bookkeeping, done.
  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      prev_stall = 0;
    end else begin
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_row", out_row, prev_row);
        check("stall_last", out_last, prev_last);
        check("stall_data", out_data === prev_data, 1);
      end
      if (bram_we) begin
        mon_r = int'(bram_addr_w[AW-1:PB]);
        check("we_addr_low", bram_addr_w[PB-1:0], 0);
        check("din_zero", bram_din == '0, 1);
        we_cnt[mon_r]++;
        we_cyc[mon_r] = cyc;
        we_total++;
      end
      if (scan_clr) check("fifo_occupancy", (we_total - acc_total) <= FD, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got row %0d required no beat", out_row);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_row", out_row, mon_e.row);
          check("beat_last", out_last, mon_e.last);
          checks++;
          if (out_data !== mon_e.data) begin
            errors++;
            $display("FAIL beat_data: row %0d got word0 %h required word0 %h",
                     mon_e.row, out_data[63:0], mon_e.data[63:0]);
          end
          if (beat_cnt < ROWS) beat_cyc[beat_cnt] = cyc;
          beat_cnt++;
          acc_total++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_row   = out_row;
      prev_last  = out_last;
    end
  end

  task automatic preload(int m);
    @(posedge clk); #1 load_mode = m;
    @(posedge clk); #1 load_mode = 0;
  endtask

  task automatic start_scan(bit clr, int mode);
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      snap[r] = mem[r];
      exp_q.push_back('{snap[r], r, r == ROWS-1});
      we_cnt[r] = 0;
      we_cyc[r] = -1;
      beat_cyc[r] = -1;
    end
    beat_cnt = 0; first_valid_cyc = -1; we_total = 0; acc_total = 0;
    done_cnt = 0; done_cyc = -1; scan_clr = clr;
    @(posedge clk); #1;
    rdy_mode = mode; start_cyc = cyc; start = 1; clear_en = clr;
    @(posedge clk); #1;
    start = 0; clear_en = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("addr_r_row0", bram_addr_r, 0);
  endtask

  task automatic finish_scan(bit clr, int mode, bit mid_start, bit done_start);
    int n, cnt;
    bit got;
    n = 0; got = 0;
    while (n < 400 && !got) begin
      @(negedge clk); n++;
      if (mid_start) start = (n == 5);
      if (done) begin
        got = 1;
        if (done_start) start = 1;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done required done within 400 cycles");
    end
    #1;
    if (done_start) begin
      @(negedge clk); start = 0;
      check("ignore_start_in_done", busy, 0);
      repeat (3) @(negedge clk);
      check("still_idle", busy, 0);
      check("no_valid_idle", out_valid, 0);
    end
    check("queue_drained", exp_q.size(), 0);
    check("beat_count", beat_cnt, ROWS);
    check("done_once", done_cnt, 1);
    if (clr) begin
      for (int r = 0; r < ROWS; r++) begin
        check($sformatf("we_once[%0d]", r), we_cnt[r], 1);
        check($sformatf("row_zeroed[%0d]", r), mem[r] === '0, 1);
      end
    end else begin
      check("no_we", we_total, 0);
      for (int r = 0; r < ROWS; r++)
        check($sformatf("row_intact[%0d]", r), mem[r] === snap[r], 1);
    end
    if (mode == 0) begin
      check("first_valid_latency", first_valid_cyc - start_cyc, 4);
      for (int i = 0; i < ROWS; i++)
        check($sformatf("beat_cycle[%0d]", i), beat_cyc[i] - start_cyc, 4 + i);
      check("done_after_last", done_cyc - beat_cyc[ROWS-1], 1);
      if (clr)
        for (int r = 0; r < ROWS; r++)
          check($sformatf("we_cycle[%0d]", r), we_cyc[r] - start_cyc, 4 + r);
    end
    if (mode == 3) begin
      cnt = 0;
      for (int r = 0; r < ROWS; r++)
        if (we_cnt[r] > 0 && we_cyc[r] <= start_cyc + 20) cnt++;
      check("reads_during_stall", cnt, FD);
    end
  endtask

  task automatic reset_test();
    bit found;
    found = 0;
    preload(1);
    start_scan(1, 0);
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_row == 3) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL row3_timeout: got no row 3 handshake required one within 100 cycles");
    end
    @(posedge clk); #1 rst = 0; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_we", bram_we, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_addr_r", bram_addr_r, 0);
    check("mid_rst_addr_w", bram_addr_w, 0);
    check("mid_rst_row", out_row, 0);
    check("mid_rst_data", out_data == '0, 1);
    exp_q.delete();
    scan_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    for (int r = 0; r < 4; r++) check($sformatf("rst_row_cleared[%0d]", r), mem[r] === '0, 1);
    for (int r = 5; r < ROWS; r++) check($sformatf("rst_row_kept[%0d]", r), mem[r] === snap[r], 1);
    start_scan(0, 0);
    finish_scan(0, 0, 0, 0);
  endtask

  initial begin
    bit c;
    #2 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", bram_we, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_addr_r", bram_addr_r, 0);
    check("rst_addr_w", bram_addr_w, 0);
    check("rst_row", out_row, 0);
    rst = 1;

    preload(1);
    start_scan(0, 0); finish_scan(0, 0, 0, 0);
    start_scan(1, 0); finish_scan(1, 0, 0, 0);

    preload(2);
    start_scan(1, 1); finish_scan(1, 1, 1, 0);

    preload(2);
    start_scan(1, 3); finish_scan(1, 3, 0, 0);

    preload(2);
    start_scan(0, 0); finish_scan(0, 0, 0, 1);

    for (int t = 0; t < 3; t++) begin
      preload(2);
      c = 1'($urandom_range(0, 1));
      start_scan(c, 2); finish_scan(c, 2, 0, 0);
    end

    reset_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish required finish before 300000 ns");
    $fatal(1);
  end
endmodule
